// File: rtl/mem_arbiter.sv
// mem_arbiter
//
// Shares the single RAM port between the icache and the dcache. Data requests
// normally win. After MAXD data grants in a row while an instruction fetch is
// waiting, the fetch is granted next. Each transaction costs one IDLE cycle
// for arbitration, then one or more grant cycles until the RAM reports ACCESS.
//
// Ports
//   CLK, nRST              clock (rising edge), asynchronous active-low reset
//   iREN, iaddr            icache fetch request and word address
//   iwait, iload           icache handshake: iwait low for the one cycle iload is valid
//   dREN, dWEN, daddr,     dcache read/write request, word address, write data
//   dstore
//   dwait, dload           dcache handshake: dwait low for the one cycle the access completes
//   ramREN, ramWEN,        RAM port: enables, address, write data
//   ramaddr, ramstore
//   ramload, ramstate      RAM read data and status (FREE/BUSY/ACCESS/ERROR)
//   err                    sticky flag: RAM reported ERROR at least once since reset
module mem_arbiter #(
    parameter int MAXD   = 4,
    parameter int WORD_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [WORD_W-1:0] iaddr,
    output logic              iwait,
    output logic [WORD_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [WORD_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic              dwait,
    output logic [WORD_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic              err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] DGNT = 2'd1;
    localparam logic [1:0] IGNT = 2'd2;

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    localparam int              CNT_W   = $clog2(MAXD + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAXD);

    logic [1:0]       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             err_reg, err_next;
    logic             d_req;

    assign d_req = dREN | dWEN;
    assign err   = err_reg;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            err_reg   <= err_next;
        end
    end

    // The RAM port is steered combinationally from the live cache inputs, so a
    // requester that changes address or drops its request mid-grant is seen at
    // the RAM in the same cycle.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        err_next   = err_reg;
        iwait      = 1'b1;
        dwait      = 1'b1;
        iload      = '0;
        dload      = '0;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = '0;
        ramstore   = '0;

        case (state_reg)
            IDLE: begin
                if (d_req && (!iREN || (cnt_reg < CNT_MAX))) begin
                    state_next = DGNT;
                    // Only consecutive data grants that overtake a waiting
                    // fetch count towards the starvation limit. The guard
                    // above keeps the increment from passing CNT_MAX.
                    cnt_next   = iREN ? (cnt_reg + CNT_W'(1)) : '0;
                end else if (iREN) begin
                    state_next = IGNT;
                    cnt_next   = '0;
                end
            end

            DGNT: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;  // a write takes precedence over a read
                if (!d_req) begin
                    state_next = IDLE;    // withdrawn: no completion pulse
                end else if (ramstate == RAM_ACCESS) begin
                    dwait      = 1'b0;
                    dload      = ramload;
                    state_next = IDLE;
                end else if (ramstate == RAM_ERROR) begin
                    err_next   = 1'b1;    // keep the grant; request is re-presented
                end
            end

            IGNT: begin
                ramREN  = iREN;
                ramaddr = iaddr;
                if (!iREN) begin
                    state_next = IDLE;
                end else if (ramstate == RAM_ACCESS) begin
                    iwait      = 1'b0;
                    iload      = ramload;
                    state_next = IDLE;
                end else if (ramstate == RAM_ERROR) begin
                    err_next   = 1'b1;
                end
            end

            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed stimulus pushes expected load values into
// per-side queues; a monitor pops and compares whenever a wait goes low.
module tb_mem_arbiter;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    logic        err;

    int errors = 0;
    int checks = 0;

    logic [31:0] dq[$];
    logic [31:0] iq[$];

    mem_arbiter #(.MAXD(4), .WORD_W(32)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dwait    (dwait),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate),
        .err      (err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Outputs are sampled mid-cycle, away from the rising edge.
    task automatic mid();
        @(negedge CLK);
    endtask

    // Scoreboard monitor
    always @(negedge CLK) begin
        logic [31:0] exp_v;
        if (nRST === 1'b1) begin
            if (dwait === 1'b0) begin
                if (dq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL dwait_pulse: got unexpected completion dload=0x%08h, expected none", dload);
                end else begin
                    exp_v = dq.pop_front();
                    chk("dload", dload, exp_v);
                    $display("txn D  t=%0t dload=0x%08h expected=0x%08h", $time, dload, exp_v);
                end
            end else begin
                chk("dload_idle", dload, 32'h0);
            end
            if (iwait === 1'b0) begin
                if (iq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL iwait_pulse: got unexpected completion iload=0x%08h, expected none", iload);
                end else begin
                    exp_v = iq.pop_front();
                    chk("iload", iload, exp_v);
                    $display("txn I  t=%0t iload=0x%08h expected=0x%08h", $time, iload, exp_v);
                end
            end else begin
                chk("iload_idle", iload, 32'h0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion in bound");
        $fatal(1);
    end

    initial begin
        logic [9:0] pat;
        int         n;

        // Reset with random inputs
        nRST = 1'b0;
        for (int k = 0; k < 3; k++) begin
            iREN     = 1'($urandom);
            dREN     = 1'($urandom);
            dWEN     = 1'($urandom);
            iaddr    = $urandom;
            daddr    = $urandom;
            dstore   = $urandom;
            ramload  = $urandom;
            ramstate = 2'($urandom);
            step();
            mid();
            chk("rst_iwait", iwait, 1);
            chk("rst_dwait", dwait, 1);
            chk("rst_ramREN", ramREN, 0);
            chk("rst_ramWEN", ramWEN, 0);
            chk("rst_err", err, 0);
            chk("rst_ramaddr", ramaddr, 0);
        end
        iREN = 0; dREN = 0; dWEN = 0; iaddr = 0; daddr = 0; dstore = 0;
        ramload = 0; ramstate = 2'd0;
        step();
        nRST = 1'b1;
        step();

        // Single fetch, zero-latency RAM
        iREN = 1; iaddr = 32'h40; ramstate = 2'd2; ramload = 32'h8C220004;
        iq.push_back(32'h8C220004);
        mid();
        chk("fetch_c1_iwait", iwait, 1);
        chk("fetch_c1_ramREN", ramREN, 0);
        step();
        mid();
        chk("fetch_c2_ramREN", ramREN, 1);
        chk("fetch_c2_ramaddr", ramaddr, 32'h40);
        chk("fetch_c2_iwait", iwait, 0);
        chk("fetch_c2_iload", iload, 32'h8C220004);
        step();
        iREN = 0; ramstate = 2'd0;
        mid();
        chk("fetch_c3_iwait", iwait, 1);
        chk("fetch_c3_iload", iload, 0);

        // Data write with three BUSY grant cycles
        step();
        dWEN = 1; daddr = 32'h100; dstore = 32'hDEADBEEF; ramstate = 2'd1;
        ramload = 32'h0BADF00D;
        mid();
        for (int g = 1; g <= 4; g++) begin
            step();
            if (g == 4) begin
                ramstate = 2'd2;
                dq.push_back(ramload);
            end
            mid();
            chk("wr_ramWEN", ramWEN, 1);
            chk("wr_ramREN", ramREN, 0);
            chk("wr_ramaddr", ramaddr, 32'h100);
            chk("wr_ramstore", ramstore, 32'hDEADBEEF);
            chk("wr_iwait", iwait, 1);
            chk("wr_dwait", dwait, (g == 4) ? 32'd0 : 32'd1);
        end
        step();
        dWEN = 0; ramstate = 2'd0;
        mid();
        chk("wr_done_ramWEN", ramWEN, 0);
        chk("wr_done_dwait", dwait, 1);

        // dREN and dWEN together: the write wins
        step();
        dREN = 1; dWEN = 1; daddr = 32'h200; dstore = 32'hCAFEF00D;
        ramstate = 2'd2; ramload = 32'h13572468;
        dq.push_back(32'h13572468);
        mid();
        step();
        mid();
        chk("rw_ramWEN", ramWEN, 1);
        chk("rw_ramREN", ramREN, 0);
        chk("rw_ramstore", ramstore, 32'hCAFEF00D);
        chk("rw_ramaddr", ramaddr, 32'h200);
        step();
        dREN = 0; dWEN = 0; ramstate = 2'd0;
        mid();
        chk("rw_done_ramWEN", ramWEN, 0);

        // ERROR for two grant cycles then ACCESS
        step();
        dREN = 1; daddr = 32'h300; ramstate = 2'd3;
        mid();
        chk("er_idle_err", err, 0);
        step();
        mid();
        chk("er_g1_ramREN", ramREN, 1);
        chk("er_g1_dwait", dwait, 1);
        chk("er_g1_err", err, 0);
        step();
        mid();
        chk("er_g2_err", err, 1);
        chk("er_g2_dwait", dwait, 1);
        chk("er_g2_ramREN", ramREN, 1);
        step();
        ramstate = 2'd2; ramload = 32'h55AA33CC;
        dq.push_back(32'h55AA33CC);
        mid();
        chk("er_g3_dwait", dwait, 0);
        chk("er_g3_err", err, 1);
        step();
        dREN = 0; ramstate = 2'd0;
        mid();
        chk("er_after_err", err, 1);
        chk("er_after_dwait", dwait, 1);

        // Withdrawal of a data request while an instruction request waits
        step();
        dREN = 1; iREN = 1; daddr = 32'h400; iaddr = 32'h44; ramstate = 2'd1;
        mid();
        chk("wd_idle_ramREN", ramREN, 0);
        step();
        mid();
        chk("wd_dg_ramREN", ramREN, 1);
        chk("wd_dg_ramaddr", ramaddr, 32'h400);
        chk("wd_dg_iwait", iwait, 1);
        step();
        dREN = 0;
        mid();
        chk("wd_drop_ramREN", ramREN, 0);
        chk("wd_drop_dwait", dwait, 1);
        step();
        mid();
        chk("wd_idle2_ramREN", ramREN, 0);
        chk("wd_idle2_ramaddr", ramaddr, 0);
        chk("wd_idle2_dwait", dwait, 1);
        chk("wd_idle2_iwait", iwait, 1);
        step();
        ramstate = 2'd2; ramload = 32'h0000BEEF;
        iq.push_back(32'h0000BEEF);
        mid();
        chk("wd_ig_ramREN", ramREN, 1);
        chk("wd_ig_ramaddr", ramaddr, 32'h44);
        step();
        iREN = 0; ramstate = 2'd0;
        mid();

        // Starvation bound: both sides requesting, RAM always ACCESS
        step();
        iREN = 1; dREN = 1; daddr = 32'h500; iaddr = 32'h600;
        ramstate = 2'd2; ramload = 32'h12345678;
        pat = 10'b10_0001_0000;  // bit n set = grant n goes to the icache
        for (int k = 0; k < 10; k++) begin
            if (pat[k]) iq.push_back(32'h12345678);
            else        dq.push_back(32'h12345678);
        end
        n = 0;
        for (int cyc = 0; cyc < 40 && n < 10; cyc++) begin
            mid();
            if (ramREN === 1'b1) begin
                chk("grant_order", (ramaddr == 32'h600) ? 32'd1 : 32'd0, {31'd0, pat[n]});
                $display("grant %0d: %s", n, (ramaddr == 32'h600) ? "I" : "D");
                n++;
            end
            step();
        end
        chk("grant_count", 32'(n), 32'd10);
        iREN = 0; dREN = 0; ramstate = 2'd0;
        mid();
        chk("starve_end_ramREN", ramREN, 0);

        // Reset asserted in the middle of a data grant
        step();
        dWEN = 1; daddr = 32'h700; dstore = 32'h1; ramstate = 2'd1;
        mid();
        step();
        mid();
        chk("mr_dg_ramWEN", ramWEN, 1);
        #1;
        nRST = 1'b0;
        ramstate = 2'd2;
        #1;
        chk("mr_ramWEN", ramWEN, 0);
        chk("mr_ramREN", ramREN, 0);
        chk("mr_dwait", dwait, 1);
        chk("mr_iwait", iwait, 1);
        chk("mr_err", err, 0);
        chk("mr_ramaddr", ramaddr, 0);
        chk("mr_ramstore", ramstore, 0);
        step();
        step();
        dWEN = 0; ramstate = 2'd0;
        nRST = 1'b1;
        step();
        mid();
        chk("mr_post_dwait", dwait, 1);
        chk("mr_post_ramWEN", ramWEN, 0);
        step();

        chk("dq_empty", 32'(dq.size()), 32'd0);
        chk("iq_empty", 32'(iq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
